// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART transmitter.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with combinational read of the head entry.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] LevelFull = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LevelFull);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Guard against illegal pushes/pops so the level never leaves 0..DEPTH.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of 2).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + (PtrW + 1)'(1);
            2'b01:   level_d = level_q - (PtrW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage write; contents are left stale on reset, only pointers matter.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointer and level registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/uart_tx_gen.sv
// UART transmitter: input FIFO, frame FSM, baud counter and LSB-first shifter.
module uart_tx_gen
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             P_DATA,
    input  logic                          DATA_VALID,
    output logic                          DATA_READY,
    input  logic                          PAR_EN,
    input  logic                          PAR_TYP,
    input  logic                          STOP2,
    output logic                          TX_OUT,
    output logic                          Busy,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    localparam int unsigned BaudW = cnt_width(CLKS_PER_BIT);
    localparam int unsigned BitW  = $clog2(DATA_W + 1);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              par_en_q, par_en_d;
    logic              par_typ_q, par_typ_d;
    logic              stop2_q, stop2_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              fifo_empty_q;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              bit_end, par_bit;

    assign fifo_push  = DATA_VALID && !fifo_full;
    assign DATA_READY = !fifo_full;
    assign TX_OUT     = tx_q;
    assign Busy       = busy_q;

    uart_tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .wdata_i (P_DATA),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (FIFO_LEVEL)
    );

    // Frame sequencing: baud/bit counting, shifting and the pop/latch of the next word.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        word_d    = word_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        stop2_d   = stop2_q;
        fifo_pop  = 1'b0;
        bit_end   = (baud_q == BaudLast);

        if (state_q != StIdle) begin
            baud_d = bit_end ? '0 : baud_q + BaudW'(1);
        end

        unique case (state_q)
            // Idle acts on the FIFO status from the previous cycle, so a push
            // into an empty FIFO reaches the line two edges later.
            StIdle: fifo_pop = !fifo_empty_q && !fifo_empty;
            StStart: begin
                if (bit_end) state_d = StData;
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BitLast) begin
                        bit_d   = '0;
                        state_d = par_en_q ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
            StParity: begin
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                // bit_q doubles as the stop-bit index here.
                if (bit_end) begin
                    if (stop2_q && (bit_q == '0)) begin
                        bit_d = BitW'(1);
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_d = StIdle;
                        bit_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Popping always starts a new frame with the configuration frozen for its duration.
        if (fifo_pop) begin
            state_d   = StStart;
            baud_d    = '0;
            bit_d     = '0;
            shift_d   = fifo_rdata;
            word_d    = fifo_rdata;
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
            stop2_d   = STOP2;
        end
    end

    // Line level and busy flag for the state being entered, so both are registered.
    always_comb begin
        par_bit = (par_typ_q == PAR_EVEN) ? ^word_q : ~^word_q;
        tx_d    = 1'b1;
        unique case (state_d)
            StIdle:   tx_d = 1'b1;
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = par_bit;
            StStop:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
    end

    // State, counters, datapath and latched configuration.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            stop2_q      <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            fifo_empty_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            stop2_q      <= stop2_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            fifo_empty_q <= fifo_empty;
        end
    end

endmodule

// File: tb/tb_uart_tx_gen.sv
// Bench for uart_tx_gen: per-cycle line/handshake model plus directed frame checks.
module tb_uart_tx_gen;

    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       DATA_READY;
    logic       PAR_EN, PAR_TYP, STOP2;
    logic       TX_OUT;
    logic       Busy;
    logic [2:0] FIFO_LEVEL;

    int checks = 0;
    int errors = 0;

    uart_tx_gen #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy),
        .FIFO_LEVEL (FIFO_LEVEL)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: one entry per future clock cycle describing the expected line.
    typedef struct packed {
        logic line;
        logic busy;
        logic pop;
    } ent_t;

    ent_t wq[$];
    ent_t cur;
    int   m_level    = 0;
    bit   model_live = 1'b0;

    function automatic void add_frame(input logic [7:0] w, input logic pe, input logic pt,
                                      input logic s2);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(w[i]);
        // Parity bit brings the count of ones to even (pt=0) or odd (pt=1).
        if (pe) bits.push_back(logic'(($countones(w) % 2) == 1) ^ pt);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int c = 0; c < CPB; c++) begin
                wq.push_back('{line: bits[k], busy: 1'b1, pop: (k == 0 && c == 0)});
            end
        end
    endfunction

    always @(posedge clk) begin
        logic acc;
        ent_t e;
        acc = DATA_VALID && (m_level < DEPTH);
        if (reset) begin
            wq.delete();
            cur        = '{line: 1'b1, busy: 1'b0, pop: 1'b0};
            m_level    = 0;
            model_live = 1'b1;
        end else if (model_live) begin
            if (wq.size() > 0) e = wq.pop_front();
            else e = '{line: 1'b1, busy: 1'b0, pop: 1'b0};
            cur     = e;
            m_level = m_level - (e.pop ? 1 : 0) + (acc ? 1 : 0);
            if (acc) begin
                // From idle the word waits one cycle; behind a frame it follows seamlessly.
                if (wq.size() == 0 && !cur.busy) wq.push_back('{line: 1'b1, busy: 1'b0, pop: 1'b0});
                add_frame(P_DATA, PAR_EN, PAR_TYP, STOP2);
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("tx_out", 32'(TX_OUT), 32'(cur.line));
            check("busy", 32'(Busy), 32'(cur.busy));
            check("fifo_level", 32'(FIFO_LEVEL), 32'(m_level));
            check("data_ready", 32'(DATA_READY), 32'(m_level < DEPTH));
        end
    end

    // Length of the most recent completed run of Busy high.
    int busy_run = 0;
    int busy_run_last = 0;
    always @(negedge clk) begin
        if (Busy === 1'b1) busy_run++;
        else if (busy_run > 0) begin
            busy_run_last = busy_run;
            busy_run = 0;
        end
    end

    task automatic push_word(input logic [7:0] w, output int wait_cyc);
        P_DATA     = w;
        DATA_VALID = 1'b1;
        wait_cyc   = 0;
        while (DATA_READY !== 1'b1 && wait_cyc < 200) begin
            @(posedge clk);
            #1;
            wait_cyc++;
        end
        if (DATA_READY !== 1'b1) check("push_timeout", 32'(wait_cyc), 32'd0);
        @(posedge clk);
        #1;
        DATA_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((Busy !== 1'b0 || FIFO_LEVEL != 0 || wq.size() != 0) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) check({tag, "_idle_timeout"}, 32'(n), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Samples n bits mid-bit, starting in the first cycle of the start bit.
    task automatic sample_bits(input int n, output logic [15:0] bits);
        bits = '0;
        for (int i = 0; i < n; i++) begin
            repeat (CPB / 2) @(posedge clk);
            #1;
            bits[i] = TX_OUT;
            repeat (CPB - CPB / 2) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int          wc;
        int          n_low, n_high;
        logic [15:0] bits;

        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          wc;
        int          n_low, n_high;
        logic [15:0] bits;

        reset      = 1'b1;
        P_DATA     = '0;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        STOP2      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_tx", 32'(TX_OUT), 32'd1);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_ready", 32'(DATA_READY), 32'd1);
        check("rst_level", 32'(FIFO_LEVEL), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // 1: plain 8N1 frame of 0xA5, latency and length.
        push_word(8'hA5, wc);
        check("t1_line_after_push", 32'(TX_OUT), 32'd1);
        @(posedge clk);
        #1;
        check("t1_line_edge1", 32'(TX_OUT), 32'd1);
        check("t1_busy_edge1", 32'(Busy), 32'd0);
        @(posedge clk);
        #1;
        check("t1_line_edge2", 32'(TX_OUT), 32'd0);
        check("t1_busy_edge2", 32'(Busy), 32'd1);
        sample_bits(10, bits);
        check("t1_frame_bits", 32'(bits[9:0]), 32'b11_0100_1010);
        wait_idle("t1");
        check("t1_busy_len", 32'(busy_run_last), 32'd40);

        // 2: parity variants.
        PAR_EN  = 1'b1;
        PAR_TYP = 1'b0;
        push_word(8'hA5, wc);
        repeat (2) @(posedge clk);
        #1;
        sample_bits(11, bits);
        check("t2_even_a5", 32'(bits[9]), 32'd0);
        wait_idle("t2a");
        check("t2_busy_len", 32'(busy_run_last), 32'd44);
        PAR_TYP = 1'b1;
        push_word(8'hA5, wc);
        repeat (2) @(posedge clk);
        #1;
        sample_bits(11, bits);
        check("t2_odd_a5", 32'(bits[9]), 32'd1);
        wait_idle("t2b");
        PAR_TYP = 1'b0;
        push_word(8'h07, wc);
        repeat (2) @(posedge clk);
        #1;
        sample_bits(11, bits);
        check("t2_even_07", 32'(bits[9]), 32'd1);
        wait_idle("t2c");

        // 3: two stop bits; config changed mid-frame must not affect it.
        PAR_EN = 1'b0;
        STOP2  = 1'b1;
        push_word(8'h00, wc);
        repeat (2) @(posedge clk);
        #1;
        STOP2  = 1'b0;
        PAR_EN = 1'b1;
        n_low  = 0;
        while (TX_OUT === 1'b0 && n_low < 200) begin
            n_low++;
            @(posedge clk);
            #1;
        end
        n_high = 0;
        while (Busy === 1'b1 && n_high < 200) begin
            if (TX_OUT === 1'b1) n_high++;
            @(posedge clk);
            #1;
        end
        check("t3_low_len", 32'(n_low), 32'd36);
        check("t3_high_len", 32'(n_high), 32'd8);
        PAR_EN = 1'b0;
        wait_idle("t3");
        check("t3_busy_len", 32'(busy_run_last), 32'd44);

        // 4: three words back-to-back.
        push_word(8'h11, wc);
        push_word(8'h22, wc);
        push_word(8'h33, wc);
        check("t4_level", 32'(FIFO_LEVEL), 32'd2);
        wait_idle("t4");
        check("t4_busy_len", 32'(busy_run_last), 32'd120);

        // 5: six words offered continuously; the sixth waits for the second pop.
        for (int k = 0; k < 5; k++) push_word(8'(8'h40 + k), wc);
        check("t5_level_full", 32'(FIFO_LEVEL), 32'd4);
        check("t5_ready_low", 32'(DATA_READY), 32'd0);
        push_word(8'h45, wc);
        check("t5_sixth_wait", 32'(wc), 32'd38);
        wait_idle("t5");
        check("t5_busy_len", 32'(busy_run_last), 32'd240);

        // 6: reset during the fifth data bit.
        push_word(8'hE5, wc);
        push_word(8'h99, wc);
        repeat (22) @(posedge clk);
        #1;
        check("t6_pre_tx", 32'(TX_OUT), 32'd0);
        check("t6_pre_level", 32'(FIFO_LEVEL), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t6_rst_tx", 32'(TX_OUT), 32'd1);
        check("t6_rst_busy", 32'(Busy), 32'd0);
        check("t6_rst_level", 32'(FIFO_LEVEL), 32'd0);
        check("t6_rst_ready", 32'(DATA_READY), 32'd1);
        push_word(8'h5A, wc);
        wait_idle("t6");
        check("t6_busy_len", 32'(busy_run_last), 32'd40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_gen.md
Name:
uart_tx_gen

Overview:
Parametrised UART transmitter that serialises parallel words onto a single line, LSB first, with per-frame parity and stop-bit configuration. An internal FIFO with a valid/ready handshake lets the host queue words ahead of the serialiser. Frames queued back-to-back are sent without idle gaps. It sits between the host data path and the TX pad, with the same frame format family as the existing transmitter.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 16, clk cycles per serial bit; must be at least 2.
FIFO_DEPTH, 4, input FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
P_DATA  in  DATA_W  word to transmit
DATA_VALID  in  1  host offers P_DATA
DATA_READY  out  1  FIFO can accept; push when DATA_VALID && DATA_READY
PAR_EN  in  1  parity bit enabled
PAR_TYP  in  1  0 = even, 1 = odd
STOP2  in  1  0 = one stop bit, 1 = two stop bits
TX_OUT  out  1  serial line, idle high
Busy  out  1  frame in progress
FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset: one clock, synchronous, active-high; reset is sampled on the rising edge of clk.
  - After reset: TX_OUT=1, Busy=0, DATA_READY=1, FIFO_LEVEL=0, FSM=IDLE.
  - FIFO contents are discarded and the bit/cycle counters are cleared.
  - Reset asserted mid-frame aborts the frame; TX_OUT returns to 1 at the next edge, with no partial stop bit.
- FIFO:
  - DATA_READY = !full, registered-equivalent (it is a function of FIFO_LEVEL only).
  - A push while full is impossible by the handshake.
  - Push and pop in the same cycle leave FIFO_LEVEL unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TX_OUT=1, Busy=0. If the FIFO is non-empty, pop; at the same edge go to START with TX_OUT<=0 and Busy<=1.
  - On pop, latch the word into a shift register, and latch PAR_EN, PAR_TYP and STOP2. Changes to these inputs mid-frame have no effect on the current frame.
  - Latency: a push into an empty FIFO while IDLE at edge N gives the pop decision in cycle N+1 and TX_OUT=0 from edge N+2.
- Bit timing: each state holds TX_OUT for exactly CLKS_PER_BIT cycles, using a baud counter from 0 to CLKS_PER_BIT-1.
- START: TX_OUT=0, then go to DATA.
- DATA:
  - TX_OUT = shift_reg[0]; shift right at the end of each bit.
  - After DATA_W bits, go to PARITY if PAR_EN, else STOP.
- PARITY:
  - Bit = ^data when PAR_TYP=0 (even), ~^data when PAR_TYP=1 (odd).
  - The bit is computed from the word latched at pop, not from the shifted remnant.
- STOP:
  - TX_OUT=1 for 1 bit, or 2 bits when STOP2 was latched.
  - At the end of the final stop bit: if the FIFO is non-empty, pop and go directly to START (no idle cycle, Busy stays 1). Otherwise go to IDLE with Busy<=0.
- Frame length in clocks: CLKS_PER_BIT*(2 + DATA_W + PAR_EN + STOP2).
- Busy = (state != IDLE), registered.
- The bit counter is sized $clog2(DATA_W+1) and does not wrap within a frame.

Decomposition:
- Package uart_tx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - parity constants PAR_EVEN=0 and PAR_ODD=1;
  - a localparam helper for the counter widths.
- One sub-module, uart_tx_fifo: a synchronous FIFO with push/pop, full/empty and level outputs, parametrised by width and depth.
- The top level holds the FSM, baud counter, shift register and latched configuration.

Test Plan:
All scenarios use DATA_W=8, CLKS_PER_BIT=4, FIFO_DEPTH=4.
1. Push 0xA5 with PAR_EN=0 and STOP2=0 -> TX_OUT bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; Busy high for exactly 40 cycles; first low 2 edges after the push.
2. Push 0xA5 with PAR_EN=1: PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1; frame is 44 cycles. Push 0x07 with PAR_TYP=0 -> parity bit 1.
3. STOP2=1 with 0x00 and no parity -> line low for 36 cycles, then high for 8; Busy falls after 44 cycles.
4. Push 3 words back-to-back (0x11, 0x22, 0x33) -> no idle cycle between frames; Busy high for 120 contiguous cycles; FIFO_LEVEL reaches 0 at the third pop.
5. Hold DATA_VALID for 6 words -> 5 accepted (1 in the shifter, 4 in the FIFO); DATA_READY low until the second pop at cycle 40+1; the 6th word is accepted then; all 6 are transmitted in order.
6. Assert reset in the 5th data bit -> next edge TX_OUT=1, Busy=0, FIFO_LEVEL=0, DATA_READY=1; the next push sends a clean, complete frame.
